// File: rtl/interface_tile_mc.sv
// interface_tile_mc: per-channel FWFT FIFOs with stream ports, SoC register access and level/error interrupts
module interface_tile_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         soc_valid,
  input  logic                         soc_write,
  input  logic [ADDR_WIDTH-1:0]        soc_addr,
  input  logic [DATA_WIDTH-1:0]        soc_wdata,
  output logic [DATA_WIDTH-1:0]        soc_rdata,
  output logic                         soc_ready,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [NUM_CH-1:0]            out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic                         irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] BAD = DATA_WIDTH'(32'hDEAD_BEEF);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(12'h000);
  localparam logic [ADDR_WIDTH-1:0] A_MODE = ADDR_WIDTH'(12'h004);
  localparam logic [ADDR_WIDTH-1:0] A_THR  = ADDR_WIDTH'(12'h008);
  localparam logic [ADDR_WIDTH-1:0] A_IEN  = ADDR_WIDTH'(12'h00C);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(12'h010);
  logic [NUM_CH-1:0] en, mode, en_lvl, en_err, st_lvl, st_err;
  logic [NUM_CH-1:0] full, empty, s_push, s_pop, c_push, c_pop, ovf, udf, hit_lvl, hit_dat, lvl_hit;
  logic [DATA_WIDTH-1:0] thresh, rdata_n;
  logic [NUM_CH*LW-1:0] level_v;
  logic [NUM_CH*DATA_WIDTH-1:0] head_v;
  logic req, wr, rd, flush;
  assign req   = soc_valid & ~soc_ready;
  assign wr    = req & soc_write;
  assign rd    = req & ~soc_write;
  assign flush = wr && soc_addr == A_CTRL && soc_wdata[16];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [LW-1:0] lvl;
    logic push, pop;
    assign full[c]    = lvl == LW'(FIFO_DEPTH);
    assign empty[c]   = lvl == '0;
    assign hit_lvl[c] = soc_addr == ADDR_WIDTH'(12'h040 + 4 * c);
    assign hit_dat[c] = soc_addr == ADDR_WIDTH'(12'h100 + 4 * c);
    assign in_ready[c]  = en[c] & ~full[c];
    assign out_valid[c] = en[c] & ~mode[c] & ~empty[c];
    assign s_push[c] = in_valid[c] & in_ready[c];
    assign s_pop[c]  = out_valid[c] & out_ready[c];
    assign c_push[c] = wr & hit_dat[c] & ~full[c] & ~s_push[c];
    assign ovf[c]    = wr & hit_dat[c] & (full[c] | s_push[c]);
    assign c_pop[c]  = rd & hit_dat[c] & mode[c] & ~empty[c];
    assign udf[c]    = rd & hit_dat[c] & empty[c];
    assign lvl_hit[c] = thresh != '0 && DATA_WIDTH'(lvl) >= thresh;
    assign push = s_push[c] | c_push[c];
    assign pop  = s_pop[c] | c_pop[c];
    assign level_v[c*LW +: LW] = lvl;
    assign head_v[c*DATA_WIDTH +: DATA_WIDTH] = mem[rptr];
    assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = empty[c] ? '0 : mem[rptr];
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        wptr <= '0;
        rptr <= '0;
        lvl  <= '0;
      end else if (flush) begin
        wptr <= '0;
        rptr <= '0;
        lvl  <= '0;
      end else begin
        wptr <= wptr + PW'(push);
        rptr <= rptr + PW'(pop);
        lvl  <= lvl + LW'(push) - LW'(pop);
      end
    always_ff @(posedge clock)
      if (push) mem[wptr] <= s_push[c] ? in_data[c*DATA_WIDTH +: DATA_WIDTH] : soc_wdata;
  end
  always_comb begin
    rdata_n = soc_addr == A_CTRL ? DATA_WIDTH'(en) :
              soc_addr == A_MODE ? DATA_WIDTH'(mode) :
              soc_addr == A_THR  ? thresh :
              soc_addr == A_IEN  ? DATA_WIDTH'({en_err, 8'(en_lvl)}) :
              soc_addr == A_STAT ? DATA_WIDTH'({st_err, 8'(st_lvl)}) : BAD;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit_lvl[i]) rdata_n = DATA_WIDTH'(level_v[i*LW +: LW]);
      if (hit_dat[i]) rdata_n = empty[i] ? BAD : head_v[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      soc_ready <= 1'b0;
      soc_rdata <= '0;
      en        <= '0;
      mode      <= '0;
      thresh    <= '0;
      en_lvl    <= '0;
      en_err    <= '0;
      st_lvl    <= '0;
      st_err    <= '0;
      irq       <= 1'b0;
    end else begin
      soc_ready <= req;
      soc_rdata <= rd ? rdata_n : '0;
      if (wr && soc_addr == A_CTRL) en <= soc_wdata[NUM_CH-1:0];
      if (wr && soc_addr == A_MODE) mode <= soc_wdata[NUM_CH-1:0];
      if (wr && soc_addr == A_THR) thresh <= soc_wdata;
      if (wr && soc_addr == A_IEN) begin
        en_lvl <= soc_wdata[NUM_CH-1:0];
        en_err <= soc_wdata[NUM_CH+7:8];
      end
      st_lvl <= lvl_hit;
      st_err <= (st_err & ~((wr && soc_addr == A_STAT) ? soc_wdata[NUM_CH+7:8] : '0)) | ovf | udf;
      irq    <= |({st_err, st_lvl} & {en_err, en_lvl});
    end
endmodule

// File: tb/tb_interface_tile_mc.sv
// tb_interface_tile_mc: directed self-checking bench for interface_tile_mc
module tb_interface_tile_mc;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NC = 4;
  logic clock, reset_n, soc_valid, soc_write, soc_ready, irq;
  logic [AW-1:0] soc_addr;
  logic [DW-1:0] soc_wdata, soc_rdata, r;
  logic [NC-1:0] in_valid, in_ready, out_valid, out_ready;
  logic [NC*DW-1:0] in_data, out_data;
  int n_assert, n_fail;
  interface_tile_mc dut (
    .clock(clock), .reset_n(reset_n), .soc_valid(soc_valid), .soc_write(soc_write),
    .soc_addr(soc_addr), .soc_wdata(soc_wdata), .soc_rdata(soc_rdata), .soc_ready(soc_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .irq(irq)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output logic [DW-1:0] q);
    int k;
    @(negedge clock);
    soc_valid = 1'b1;
    soc_write = w;
    soc_addr  = a;
    soc_wdata = d;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!soc_ready && k < 4);
    soc_valid = 1'b0;
    chk("soc_ready", soc_ready, 1);
    q = soc_rdata;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] q;
    xfer(1'b1, a, d, q);
  endtask
  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] q);
    xfer(1'b0, a, '0, q);
  endtask
  task automatic push(input int c, input logic [DW-1:0] v);
    in_valid[c] = 1'b1;
    in_data[c*DW +: DW] = v;
    @(negedge clock);
    in_valid[c] = 1'b0;
  endtask
  initial begin
    n_assert = 0;
    n_fail = 0;
    reset_n = 1'b0;
    soc_valid = 1'b0;
    soc_write = 1'b0;
    soc_addr = '0;
    soc_wdata = '0;
    in_valid = '0;
    in_data = '0;
    out_ready = '0;
    repeat (3) @(negedge clock);
    chk("rst_soc_ready", soc_ready, 0);
    chk("rst_soc_rdata", soc_rdata, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 0);
    chk("rst_irq", irq, 0);
    reset_n = 1'b1;
    wr(16'h000, 32'h1);
    chk("en_in_ready", in_ready, 4'b0001);
    for (int i = 0; i < 16; i++) push(0, 32'hA000_0000 + i);
    chk("full_in_ready", in_ready[0], 0);
    push(0, 32'h0000_0BAD);
    rd(16'h040, r);
    chk("level0_full", r, 16);
    chk("head0_first", out_data[31:0], 32'hA000_0000);
    wr(16'h000, 32'h0001_0001);
    chk("flush_out_valid", out_valid[0], 0);
    rd(16'h040, r);
    chk("level0_flushed", r, 0);
    wr(16'h000, 32'h3);
    push(1, 32'hB000_0000);
    push(1, 32'hB000_0001);
    out_ready[1] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      in_valid[1] = 1'b1;
      in_data[63:32] = 32'hB000_0002 + j;
      chk("stream_order", out_data[63:32], 32'hB000_0000 + j);
      @(negedge clock);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b0;
    rd(16'h044, r);
    chk("level1_const", r, 2);
    chk("head1_after", out_data[63:32], 32'hB000_0006);
    wr(16'h000, 32'h0001_0007);
    wr(16'h004, 32'h4);
    rd(16'h108, r);
    chk("udf_rdata", r, 32'hDEAD_BEEF);
    rd(16'h010, r);
    chk("udf_stat", r, 32'h400);
    wr(16'h010, 32'h400);
    rd(16'h010, r);
    chk("udf_w1c", r, 0);
    wr(16'h108, 32'h1234);
    rd(16'h108, r);
    chk("soc_pop_data", r, 32'h1234);
    rd(16'h048, r);
    chk("soc_pop_level", r, 0);
    wr(16'h000, 32'h8);
    wr(16'h008, 32'h4);
    wr(16'h00C, 32'h8);
    chk("irq_idle", irq, 0);
    for (int i = 0; i < 4; i++) push(3, 32'hC000_0000 + i);
    chk("irq_lvl_p0", irq, 0);
    @(negedge clock);
    chk("irq_lvl_p1", irq, 0);
    @(negedge clock);
    chk("irq_lvl_p2", irq, 1);
    out_ready[3] = 1'b1;
    chk("head3_c0", out_data[127:96], 32'hC000_0000);
    @(negedge clock);
    out_ready[3] = 1'b0;
    chk("head3_c1", out_data[127:96], 32'hC000_0001);
    chk("irq_pop_q0", irq, 1);
    @(negedge clock);
    chk("irq_pop_q1", irq, 1);
    @(negedge clock);
    chk("irq_pop_q2", irq, 0);
    rd(16'h010, r);
    chk("stat_lvl_clear", r, 0);
    wr(16'h00C, 32'h0);
    wr(16'h008, 32'h0);
    wr(16'h000, 32'h0001_0001);
    @(negedge clock);
    soc_valid = 1'b1;
    soc_write = 1'b1;
    soc_addr = 16'h100;
    soc_wdata = 32'h6666;
    in_valid[0] = 1'b1;
    in_data[31:0] = 32'h5555;
    @(negedge clock);
    soc_valid = 1'b0;
    in_valid[0] = 1'b0;
    chk("coll_ready", soc_ready, 1);
    rd(16'h040, r);
    chk("coll_level", r, 1);
    chk("coll_head", out_data[31:0], 32'h5555);
    rd(16'h010, r);
    chk("coll_ovf", r, 32'h100);
    wr(16'h010, 32'h100);
    wr(16'h000, 32'h0001_0001);
    for (int i = 0; i < 5; i++) push(0, 32'hD000_0000 + i);
    rd(16'h040, r);
    chk("fill5_level", r, 5);
    chk("fill5_valid", out_valid[0], 1);
    wr(16'h000, 32'h0001_0001);
    chk("flush5_valid", out_valid[0], 0);
    rd(16'h040, r);
    chk("flush5_level", r, 0);
    rd(16'h000, r);
    chk("ctrl_selfclr", r, 1);
    rd(16'h020, r);
    chk("unmapped", r, 32'hDEAD_BEEF);
    wr(16'h040, 32'h7);
    rd(16'h040, r);
    chk("ro_ignored", r, 0);
    @(negedge clock);
    soc_valid = 1'b1;
    soc_write = 1'b0;
    soc_addr = 16'h004;
    @(negedge clock);
    chk("held_ready", soc_ready, 1);
    chk("held_rdata", soc_rdata, 4);
    @(negedge clock);
    chk("held_no_reissue", soc_ready, 0);
    soc_valid = 1'b0;
    @(negedge clock);
    soc_valid = 1'b1;
    soc_write = 1'b1;
    soc_addr = 16'h008;
    soc_wdata = 32'h9;
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("abandon_ready", soc_ready, 0);
    soc_valid = 1'b0;
    reset_n = 1'b1;
    rd(16'h008, r);
    chk("abandon_thresh", r, 0);
    rd(16'h000, r);
    chk("reset_ctrl", r, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
